// File: rtl/data_phy_if.sv
// Bundle of the control, FIFO and serial-line signals of the SD data PHY.
// The master side is data control / FIFO / card; the slave side is the PHY.
interface data_phy_if;
    logic        Send;
    logic        Idle;
    logic        WriteRead;
    logic        Timeout_enable;
    logic [15:0] Timeout_reg;
    logic [31:0] Data_from_FIFO;
    logic        Data_pin_in;
    logic        Serial_ready;
    logic        Complete;
    logic        Timeout;
    logic        Data_error;
    logic        Data_pin_out;
    logic        Read_FIFO;
    logic        Write_FIFO;
    logic [31:0] Data_to_FIFO;

    modport master (
        output Send, Idle, WriteRead, Timeout_enable, Timeout_reg, Data_from_FIFO, Data_pin_in,
        input  Serial_ready, Complete, Timeout, Data_error, Data_pin_out, Read_FIFO, Write_FIFO,
               Data_to_FIFO
    );

    modport slave (
        input  Send, Idle, WriteRead, Timeout_enable, Timeout_reg, Data_from_FIFO, Data_pin_in,
        output Serial_ready, Complete, Timeout, Data_error, Data_pin_out, Read_FIFO, Write_FIFO,
               Data_to_FIFO
    );
endinterface

// File: rtl/data_phy.sv
// SD single-line data PHY: serialises FIFO words into CRC16-protected frames and
// deserialises received frames back into FIFO words, with a start-bit timeout.
module data_phy #(
    parameter int BLOCK_WORDS = 4
) (
    input  logic       Clock,
    input  logic       Reset,
    data_phy_if.slave  bus
);
    localparam int DATA_BITS = 32 * BLOCK_WORDS;
    localparam int CW        = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(DATA_BITS - 2);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [3:0] {
        IDLE, TX_START, TX_DATA, TX_CRC, TX_END,
        RX_WAIT, RX_DATA, RX_CRC, RX_END, DONE
    } state_t;

    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    state_t        state_r;
    logic          ready_r, pin_r, complete_r, timeout_r, error_r, rd_r, wr_r;
    logic [31:0]   word_r;
    logic [31:0]   shift_r;
    logic [15:0]   crc_r;
    logic [15:0]   crc_sh_r;
    logic [CW-1:0] bit_cnt_r;
    logic [3:0]    crc_cnt_r;
    logic [15:0]   tcnt_r;

    logic [15:0]   tmax_s;
    logic [15:0]   tcnt_inc_s;
    logic [15:0]   crc_tx_s;
    logic [15:0]   crc_rx_s;
    logic          word_pre_s;
    logic [31:0]   rx_word_s;

    assign bus.Serial_ready = ready_r;
    assign bus.Data_pin_out = pin_r;
    assign bus.Complete     = complete_r;
    assign bus.Timeout      = timeout_r;
    assign bus.Data_error   = error_r;
    assign bus.Read_FIFO    = rd_r;
    assign bus.Write_FIFO   = wr_r;
    assign bus.Data_to_FIFO = word_r;

    // Next-value helpers: timeout limit, saturating wait count, CRC steps, word boundary.
    always_comb begin
        tmax_s     = (bus.Timeout_reg == 16'd0) ? 16'd1 : bus.Timeout_reg;
        tcnt_inc_s = (tcnt_r == 16'hFFFF) ? tcnt_r : (tcnt_r + 16'd1);
        crc_tx_s   = crc16_step(crc_r, pin_r);
        crc_rx_s   = crc16_step(crc_r, bus.Data_pin_in);
        rx_word_s  = {shift_r[30:0], bus.Data_pin_in};
        // Pop request must be high while the last bit of the current word is on the pin.
        word_pre_s = (bit_cnt_r[4:0] == 5'd30) && (bit_cnt_r < PRE_LAST);
    end

    // Frame FSM with all outputs registered.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r    <= IDLE;
            ready_r    <= 1'b1;
            pin_r      <= 1'b1;
            complete_r <= 1'b0;
            timeout_r  <= 1'b0;
            error_r    <= 1'b0;
            rd_r       <= 1'b0;
            wr_r       <= 1'b0;
            word_r     <= 32'h0000_0000;
            shift_r    <= 32'h0000_0000;
            crc_r      <= 16'h0000;
            crc_sh_r   <= 16'h0000;
            bit_cnt_r  <= '0;
            crc_cnt_r  <= 4'd0;
            tcnt_r     <= 16'd0;
        end else if (bus.Idle) begin
            state_r    <= IDLE;
            ready_r    <= 1'b1;
            pin_r      <= 1'b1;
            complete_r <= 1'b0;
            timeout_r  <= 1'b0;
            error_r    <= 1'b0;
            rd_r       <= 1'b0;
            wr_r       <= 1'b0;
        end else begin
            ready_r    <= 1'b0;
            pin_r      <= 1'b1;
            complete_r <= 1'b0;
            timeout_r  <= 1'b0;
            error_r    <= 1'b0;
            rd_r       <= 1'b0;
            wr_r       <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.Send) begin
                        crc_r     <= 16'h0000;
                        bit_cnt_r <= '0;
                        crc_cnt_r <= 4'd0;
                        tcnt_r    <= 16'd0;
                        if (bus.WriteRead) begin
                            state_r <= TX_START;
                            pin_r   <= 1'b0;
                            rd_r    <= 1'b1;
                        end else begin
                            state_r <= RX_WAIT;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                TX_START: begin
                    state_r <= TX_DATA;
                    pin_r   <= bus.Data_from_FIFO[31];
                    shift_r <= {bus.Data_from_FIFO[30:0], 1'b0};
                end
                TX_DATA: begin
                    crc_r <= crc_tx_s;
                    if (bit_cnt_r == LAST_BIT) begin
                        state_r  <= TX_CRC;
                        pin_r    <= crc_tx_s[15];
                        crc_sh_r <= {crc_tx_s[14:0], 1'b0};
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                        rd_r      <= word_pre_s;
                        if (rd_r) begin
                            pin_r   <= bus.Data_from_FIFO[31];
                            shift_r <= {bus.Data_from_FIFO[30:0], 1'b0};
                        end else begin
                            pin_r   <= shift_r[31];
                            shift_r <= {shift_r[30:0], 1'b0};
                        end
                    end
                end
                TX_CRC: begin
                    if (crc_cnt_r == 4'd15) begin
                        state_r <= TX_END;
                    end else begin
                        crc_cnt_r <= crc_cnt_r + 4'd1;
                        pin_r     <= crc_sh_r[15];
                        crc_sh_r  <= {crc_sh_r[14:0], 1'b0};
                    end
                end
                TX_END: begin
                    state_r    <= DONE;
                    complete_r <= 1'b1;
                end
                RX_WAIT: begin
                    // A start bit outranks a timeout match in the same cycle.
                    if (!bus.Data_pin_in) begin
                        state_r <= RX_DATA;
                    end else if (bus.Timeout_enable && (tcnt_inc_s >= tmax_s)) begin
                        state_r   <= IDLE;
                        timeout_r <= 1'b1;
                        ready_r   <= 1'b1;
                    end else begin
                        tcnt_r <= tcnt_inc_s;
                    end
                end
                RX_DATA: begin
                    crc_r   <= crc_rx_s;
                    shift_r <= rx_word_s;
                    if (bit_cnt_r[4:0] == 5'd31) begin
                        word_r <= rx_word_s;
                        wr_r   <= 1'b1;
                    end else begin
                        word_r <= word_r;
                    end
                    if (bit_cnt_r == LAST_BIT) begin
                        state_r <= RX_CRC;
                    end else begin
                        bit_cnt_r <= bit_cnt_r + CNT_ONE;
                    end
                end
                RX_CRC: begin
                    crc_sh_r <= {crc_sh_r[14:0], bus.Data_pin_in};
                    if (crc_cnt_r == 4'd15) begin
                        state_r <= RX_END;
                    end else begin
                        crc_cnt_r <= crc_cnt_r + 4'd1;
                    end
                end
                RX_END: begin
                    state_r    <= DONE;
                    complete_r <= 1'b1;
                    error_r    <= (crc_sh_r != crc_r) || !bus.Data_pin_in;
                end
                DONE: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_data_phy.sv
// Self-checking bench for data_phy (BLOCK_WORDS=1): TX framing, RX loopback and
// corruption, start-bit timeout, abort and reset behaviour.
module tb_data_phy;
    localparam int BW = 1;

    logic Clock = 1'b0;
    logic Reset;
    int   checks   = 0;
    int   failures = 0;
    logic        frame_q[$];
    logic [31:0] word_q[$];

    data_phy_if bus();
    data_phy #(.BLOCK_WORDS(BW)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

    always #5 Clock = ~Clock;

    task automatic tick();
        @(negedge Clock);
    endtask

    function automatic logic [15:0] crc16_word(input logic [31:0] w);
        logic [15:0] c;
        c = 16'h0000;
        for (int i = 31; i >= 0; i--) begin
            if (c[15] ^ w[i]) c = {c[14:0], 1'b0} ^ 16'h1021;
            else              c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    task automatic build_frame(input logic [31:0] w);
        logic [15:0] c;
        c = crc16_word(w);
        frame_q.delete();
        frame_q.push_back(1'b0);
        for (int i = 31; i >= 0; i--) frame_q.push_back(w[i]);
        for (int i = 15; i >= 0; i--) frame_q.push_back(c[i]);
        frame_q.push_back(1'b1);
    endtask

    task automatic drive_defaults();
        bus.Send = 1'b0; bus.Idle = 1'b0; bus.WriteRead = 1'b0;
        bus.Timeout_enable = 1'b0; bus.Timeout_reg = 16'd0;
        bus.Data_from_FIFO = 32'h0000_0000; bus.Data_pin_in = 1'b1;
    endtask

    task automatic test_reset();
        drive_defaults();
        Reset = 1'b1;
        repeat (3) tick();
        checks++;
        if ({bus.Serial_ready, bus.Data_pin_out, bus.Complete, bus.Timeout, bus.Data_error,
             bus.Read_FIFO, bus.Write_FIFO} !== 7'b1100000) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 1100000", {bus.Serial_ready, bus.Data_pin_out,
                     bus.Complete, bus.Timeout, bus.Data_error, bus.Read_FIFO, bus.Write_FIFO});
        end
        checks++;
        if (bus.Data_to_FIFO !== 32'h0000_0000) begin
            failures++; $display("FAIL reset_data: got %h expected 00000000", bus.Data_to_FIFO);
        end
        Reset = 1'b0;
        tick();
    endtask

    task automatic run_tx(input logic [31:0] w, input string name);
        int rd_count = 0; int done_cyc = 0; logic err_at_done = 1'b0;
        logic prev_rd = 1'b0; logic exp;
        build_frame(w);
        bus.Data_from_FIFO = w; bus.WriteRead = 1'b1; bus.Send = 1'b1;
        tick();
        bus.Send = 1'b0;
        for (int c = 1; c <= 55; c++) begin
            if (prev_rd) bus.Data_from_FIFO = ~w;
            prev_rd = bus.Read_FIFO;
            if (bus.Read_FIFO) rd_count++;
            if (bus.Complete && done_cyc == 0) begin done_cyc = c; err_at_done = bus.Data_error; end
            exp = (frame_q.size() > 0) ? frame_q.pop_front() : 1'b1;
            checks++;
            if (bus.Data_pin_out !== exp) begin
                failures++;
                $display("FAIL %s pin cycle %0d: got %b expected %b", name, c, bus.Data_pin_out, exp);
            end
            if (c == 1) begin
                checks++;
                if (bus.Serial_ready !== 1'b0 || bus.Read_FIFO !== 1'b1) begin
                    failures++;
                    $display("FAIL %s first cycle ready/read: got %b%b expected 01", name,
                             bus.Serial_ready, bus.Read_FIFO);
                end
            end
            tick();
        end
        checks++;
        if (rd_count != 1) begin failures++; $display("FAIL %s read count: got %0d expected 1", name, rd_count); end
        checks++;
        if (done_cyc != 51 || err_at_done !== 1'b0) begin
            failures++;
            $display("FAIL %s complete: got cycle %0d err %b expected cycle 51 err 0", name, done_cyc, err_at_done);
        end
        checks++;
        if (bus.Serial_ready !== 1'b1) begin failures++; $display("FAIL %s ready after: got %b expected 1", name, bus.Serial_ready); end
    endtask

    task automatic run_rx(input logic [31:0] w, input int flip_idx, input logic exp_err, input string name);
        int writes = 0; int done_cyc = 0; logic err_at_done = 1'b0; logic pin_low = 1'b0;
        logic [31:0] expw;
        build_frame(w);
        if (flip_idx >= 0) frame_q[flip_idx] = ~frame_q[flip_idx];
        word_q.push_back(w);
        bus.WriteRead = 1'b0; bus.Send = 1'b1; bus.Data_pin_in = 1'b1;
        tick();
        bus.Send = 1'b0;
        for (int c = 1; c <= 55; c++) begin
            if (bus.Write_FIFO) begin
                writes++; checks++;
                if (word_q.size() == 0) begin
                    failures++; $display("FAIL %s unexpected write cycle %0d: got %h expected none", name, c, bus.Data_to_FIFO);
                end else begin
                    expw = word_q.pop_front();
                    if (bus.Data_to_FIFO !== expw) begin
                        failures++; $display("FAIL %s word: got %h expected %h", name, bus.Data_to_FIFO, expw);
                    end
                end
            end
            if (bus.Complete && done_cyc == 0) begin done_cyc = c; err_at_done = bus.Data_error; end
            if (bus.Data_pin_out !== 1'b1) pin_low = 1'b1;
            bus.Data_pin_in = (frame_q.size() > 0) ? frame_q.pop_front() : 1'b1;
            tick();
        end
        checks++;
        if (writes != 1 || word_q.size() != 0) begin
            failures++; $display("FAIL %s write count: got %0d expected 1", name, writes);
            word_q.delete();
        end
        checks++;
        if (done_cyc != 51 || err_at_done !== exp_err) begin
            failures++;
            $display("FAIL %s complete: got cycle %0d err %b expected cycle 51 err %b", name, done_cyc, err_at_done, exp_err);
        end
        checks++;
        if (pin_low) begin failures++; $display("FAIL %s pin_out during rx: got 0 expected 1", name); end
    endtask

    task automatic test_tx();
        run_tx(32'hA5A5_0001, "tx_a5a50001");
    endtask

    task automatic test_back_to_back();
        run_tx(32'h0000_0000, "tx_zero");
        run_tx(32'hFFFF_FFFF, "tx_ones");
        run_tx(32'h8000_0001, "tx_edges");
    endtask

    task automatic test_rx();
        run_rx(32'hA5A5_0001, -1, 1'b0, "rx_loopback");
        run_rx(32'h1234_5678, -1, 1'b0, "rx_pattern");
        run_rx(32'hA5A5_0001, 38, 1'b1, "rx_crc_flip");
        run_rx(32'hA5A5_0001, 49, 1'b1, "rx_end_bit");
    endtask

    task automatic test_timeout();
        logic seen;
        bus.Timeout_enable = 1'b1; bus.Timeout_reg = 16'd70; bus.WriteRead = 1'b0;
        bus.Data_pin_in = 1'b1; bus.Send = 1'b1;
        tick(); bus.Send = 1'b0;
        for (int c = 1; c <= 75; c++) begin
            checks++;
            if (bus.Timeout !== (c == 71)) begin
                failures++; $display("FAIL timeout70 cycle %0d: got %b expected %b", c, bus.Timeout, (c == 71));
            end
            if (c == 70 || c == 71) begin
                checks++;
                if (bus.Serial_ready !== (c == 71)) begin
                    failures++; $display("FAIL timeout70 ready cycle %0d: got %b expected %b", c, bus.Serial_ready, (c == 71));
                end
            end
            tick();
        end
        // start bit arriving in the match cycle
        seen = 1'b0;
        bus.Send = 1'b1; tick(); bus.Send = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            if (bus.Timeout) seen = 1'b1;
            if (c == 71) begin
                checks++;
                if (bus.Serial_ready !== 1'b0) begin failures++; $display("FAIL start_wins ready: got %b expected 0", bus.Serial_ready); end
            end
            bus.Data_pin_in = (c == 70) ? 1'b0 : 1'b1;
            tick();
        end
        checks++;
        if (seen) begin failures++; $display("FAIL start_wins timeout: got 1 expected 0"); end
        bus.Idle = 1'b1; tick(); bus.Idle = 1'b0; tick();
        // zero limit behaves as one
        bus.Timeout_reg = 16'd0; bus.Send = 1'b1; tick(); bus.Send = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            checks++;
            if (bus.Timeout !== (c == 2)) begin
                failures++; $display("FAIL timeout0 cycle %0d: got %b expected %b", c, bus.Timeout, (c == 2));
            end
            tick();
        end
        // disabled: waits indefinitely
        seen = 1'b0;
        bus.Timeout_enable = 1'b0; bus.Timeout_reg = 16'd3; bus.Send = 1'b1; tick(); bus.Send = 1'b0;
        for (int c = 1; c <= 200; c++) begin
            if (bus.Timeout || bus.Serial_ready) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin failures++; $display("FAIL timeout_disabled: got timeout/ready expected wait"); end
        bus.Idle = 1'b1; tick(); bus.Idle = 1'b0; tick();
    endtask

    task automatic test_abort();
        logic seen = 1'b0;
        bus.Data_from_FIFO = 32'hA5A5_0001; bus.WriteRead = 1'b1; bus.Send = 1'b1;
        tick(); bus.Send = 1'b0;
        for (int c = 1; c < 12; c++) tick();
        bus.Idle = 1'b1;
        tick();
        bus.Idle = 1'b0;
        checks++;
        if ({bus.Serial_ready, bus.Data_pin_out, bus.Complete, bus.Read_FIFO} !== 4'b1100) begin
            failures++;
            $display("FAIL abort_tx: got %b expected 1100", {bus.Serial_ready, bus.Data_pin_out, bus.Complete, bus.Read_FIFO});
        end
        for (int c = 0; c < 45; c++) begin
            if (bus.Complete || !bus.Serial_ready || !bus.Data_pin_out) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen) begin failures++; $display("FAIL abort_quiet: got activity expected idle"); end
        // Idle outranks Send
        bus.WriteRead = 1'b1; bus.Send = 1'b1; bus.Idle = 1'b1;
        tick();
        bus.Send = 1'b0; bus.Idle = 1'b0;
        checks++;
        if (bus.Serial_ready !== 1'b1 || bus.Data_pin_out !== 1'b1) begin
            failures++; $display("FAIL idle_priority: got %b%b expected 11", bus.Serial_ready, bus.Data_pin_out);
        end
        // reset in the middle of a receive
        bus.WriteRead = 1'b0; bus.Send = 1'b1; tick(); bus.Send = 1'b0;
        for (int c = 1; c < 20; c++) begin
            bus.Data_pin_in = (c == 1) ? 1'b0 : c[0];
            tick();
        end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        bus.Data_pin_in = 1'b1;
        checks++;
        if ({bus.Serial_ready, bus.Data_pin_out, bus.Complete, bus.Timeout, bus.Data_error,
             bus.Read_FIFO, bus.Write_FIFO} !== 7'b1100000) begin
            failures++;
            $display("FAIL reset_mid_rx flags: got %b expected 1100000", {bus.Serial_ready, bus.Data_pin_out,
                     bus.Complete, bus.Timeout, bus.Data_error, bus.Read_FIFO, bus.Write_FIFO});
        end
        checks++;
        if (bus.Data_to_FIFO !== 32'h0000_0000) begin
            failures++; $display("FAIL reset_mid_rx data: got %h expected 00000000", bus.Data_to_FIFO);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_tx();
        test_back_to_back();
        test_rx();
        test_timeout();
        test_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
